// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared state encoding, fixed-point format and address-width helpers for the
// fully-connected layer sequencer, its MAC and the neuron datapath.
package neuron_layer_sequencer_pkg;

  localparam int FX_INT_W  = 8;
  localparam int FX_FRAC_W = 18;
  localparam int FX_W      = FX_INT_W + FX_FRAC_W;

  localparam int DEF_NUM_NEURONS = 10;
  localparam int DEF_NUM_INPUTS  = 785;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W   = clog2_min1(DEF_NUM_NEURONS);
  localparam int PADDR_W = clog2_min1(DEF_NUM_INPUTS);
  localparam int WADDR_W = clog2_min1(DEF_NUM_NEURONS * DEF_NUM_INPUTS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Control handshake plus ROM/MAC bus of the layer sequencer.
// master = sequencer side, slave = environment (controller, ROMs, MAC).
interface neuron_layer_sequencer_if #(
  parameter int NUM_NEURONS  = neuron_layer_sequencer_pkg::DEF_NUM_NEURONS,
  parameter int NUM_INPUTS   = neuron_layer_sequencer_pkg::DEF_NUM_INPUTS,
  parameter int OUTPUT_WIDTH = neuron_layer_sequencer_pkg::FX_W
);
  import neuron_layer_sequencer_pkg::*;

  localparam int IW = clog2_min1(NUM_NEURONS);
  localparam int PW = clog2_min1(NUM_INPUTS);
  localparam int WW = clog2_min1(NUM_NEURONS * NUM_INPUTS);

  logic                           start;
  logic                           busy;
  logic                           done;
  logic [IW-1:0]                  class_out;
  logic signed [OUTPUT_WIDTH-1:0] class_score;
  logic                           err;
  logic                           mem_rd_en;
  logic [PW-1:0]                  pix_addr;
  logic [WW-1:0]                  wgt_addr;
  logic                           mac_clr;
  logic                           mac_en;
  logic                           mac_last;
  logic signed [OUTPUT_WIDTH-1:0] mac_result;
  logic                           mac_valid;

  modport master (
    input  start, mac_result, mac_valid,
    output busy, done, class_out, class_score, err,
           mem_rd_en, pix_addr, wgt_addr, mac_clr, mac_en, mac_last
  );

  modport slave (
    output start, mac_result, mac_valid,
    input  busy, done, class_out, class_score, err,
           mem_rd_en, pix_addr, wgt_addr, mac_clr, mac_en, mac_last
  );

endinterface

// File: rtl/neuron_layer_sequencer_argmax_tracker.sv
// Running argmax over neuron sums: signed strictly-greater compare, so ties
// keep the earlier (lower) index. o_upd_* is the best including this input.
module argmax_tracker #(
  parameter int SCORE_W = neuron_layer_sequencer_pkg::FX_W,
  parameter int INDEX_W = neuron_layer_sequencer_pkg::IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      i_first,
  input  logic signed [SCORE_W-1:0] i_score,
  input  logic [INDEX_W-1:0]        i_idx,
  output logic signed [SCORE_W-1:0] o_upd_score,
  output logic [INDEX_W-1:0]        o_upd_idx
);
  import neuron_layer_sequencer_pkg::*;

  logic signed [SCORE_W-1:0] r_best_score;
  logic [INDEX_W-1:0]        r_best_idx;
  logic                      w_take;

  always_comb begin
    w_take = i_valid && (i_first || (i_score > r_best_score));
    if (w_take) begin
      o_upd_score = i_score;
      o_upd_idx   = i_idx;
    end else begin
      o_upd_score = r_best_score;
      o_upd_idx   = r_best_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best_score <= '0;
      r_best_idx   <= '0;
    end else if (i_valid) begin
      r_best_score <= o_upd_score;
      r_best_idx   <= o_upd_idx;
    end
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one pipelined MAC over every output neuron of a layer:
// drives ROM addresses and MAC strobes, then reports the argmax class.
module neuron_layer_sequencer #(
  parameter int NUM_NEURONS  = neuron_layer_sequencer_pkg::DEF_NUM_NEURONS,
  parameter int NUM_INPUTS   = neuron_layer_sequencer_pkg::DEF_NUM_INPUTS,
  parameter int OUTPUT_WIDTH = neuron_layer_sequencer_pkg::FX_W,
  parameter int MEM_LATENCY  = 1
) (
  input logic                      clk,
  input logic                      rst,
  neuron_layer_sequencer_if.master bus
);
  import neuron_layer_sequencer_pkg::*;

  localparam int IW = clog2_min1(NUM_NEURONS);
  localparam int PW = clog2_min1(NUM_INPUTS);
  localparam int WW = clog2_min1(NUM_NEURONS * NUM_INPUTS);
  localparam logic [IW-1:0] LAST_NEURON = IW'(NUM_NEURONS - 1);
  localparam logic [PW-1:0] LAST_INPUT  = PW'(NUM_INPUTS - 1);
  localparam logic [WW-1:0] BASE_STEP   = WW'(NUM_INPUTS);

  state_t r_state, w_next;
  logic [IW-1:0] r_neuron_idx;
  logic [PW-1:0] r_input_idx, w_rd_idx;
  logic [WW-1:0] r_wgt_base;
  logic w_accept, w_score_vld, w_rd_en, w_rd_last, w_first, w_last_neuron, w_stray;
  logic signed [OUTPUT_WIDTH-1:0] w_upd_score, r_class_score;
  logic [IW-1:0] w_upd_idx, r_class_out;
  logic r_busy, r_done, r_err, r_mem_rd_en, r_rd_last, r_mac_clr;
  logic [PW-1:0] r_pix_addr;
  logic [WW-1:0] r_wgt_addr;
  logic [MEM_LATENCY-1:0] r_en_pipe, r_last_pipe;

  assign w_first       = (r_neuron_idx == '0);
  assign w_last_neuron = (r_neuron_idx == LAST_NEURON);
  assign w_stray       = bus.mac_valid && (r_state != S_DRAIN);

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_score_vld = 1'b0;
    w_rd_idx    = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next   = S_CLEAR;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLEAR: w_next = S_STREAM;
      S_STREAM: begin
        if (r_input_idx == LAST_INPUT) begin
          w_next = S_DRAIN;
        end else begin
          w_next   = S_STREAM;
          w_rd_idx = r_input_idx + PW'(1);
        end
      end
      S_DRAIN: begin
        if (bus.mac_valid) begin
          w_score_vld = 1'b1;
          w_next      = w_last_neuron ? S_DONE : S_CLEAR;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rd_en   = (w_next == S_STREAM);
  assign w_rd_last = w_rd_en && (w_rd_idx == LAST_INPUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Weight addresses come from a running base, stepped once per neuron.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neuron_idx <= '0;
      r_wgt_base   <= '0;
      r_input_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_neuron_idx <= '0;
        r_wgt_base   <= '0;
      end else if (w_score_vld && !w_last_neuron) begin
        r_neuron_idx <= r_neuron_idx + IW'(1);
        r_wgt_base   <= r_wgt_base + BASE_STEP;
      end
      if (w_rd_en) r_input_idx <= w_rd_idx;
    end
  end

  argmax_tracker #(.SCORE_W(OUTPUT_WIDTH), .INDEX_W(IW)) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (w_score_vld),
    .i_first     (w_first),
    .i_score     (bus.mac_result),
    .i_idx       (r_neuron_idx),
    .o_upd_score (w_upd_score),
    .o_upd_idx   (w_upd_idx)
  );

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_mac_clr     <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_rd_last     <= 1'b0;
      r_pix_addr    <= '0;
      r_wgt_addr    <= '0;
      r_class_out   <= '0;
      r_class_score <= '0;
      r_en_pipe     <= '0;
      r_last_pipe   <= '0;
    end else begin
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      r_mac_clr   <= (w_next == S_CLEAR);
      r_mem_rd_en <= w_rd_en;
      r_rd_last   <= w_rd_last;
      r_pix_addr  <= w_rd_en ? w_rd_idx : '0;
      r_wgt_addr  <= w_rd_en ? (r_wgt_base + WW'(w_rd_idx)) : '0;
      if (w_stray)       r_err <= 1'b1;
      else if (w_accept) r_err <= 1'b0;
      if (w_next == S_DONE) begin
        r_class_out   <= w_upd_idx;
        r_class_score <= w_upd_score;
      end
      r_en_pipe[0]   <= r_mem_rd_en;
      r_last_pipe[0] <= r_rd_last;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        r_en_pipe[k]   <= r_en_pipe[k-1];
        r_last_pipe[k] <= r_last_pipe[k-1];
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.class_out   = r_class_out;
  assign bus.class_score = r_class_score;
  assign bus.mem_rd_en   = r_mem_rd_en;
  assign bus.pix_addr    = r_pix_addr;
  assign bus.wgt_addr    = r_wgt_addr;
  assign bus.mac_clr     = r_mac_clr;
  assign bus.mac_en      = r_en_pipe[MEM_LATENCY-1];
  assign bus.mac_last    = r_last_pipe[MEM_LATENCY-1];

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Scoreboard bench: 3 neurons x 4 inputs, ROM latency 1, MAC stub with L=2.
module tb_neuron_layer_sequencer;

  localparam int NN = 3;
  localparam int NI = 4;
  localparam int OW = 26;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_layer_sequencer_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .OUTPUT_WIDTH(OW)) bus ();

  neuron_layer_sequencer #(
    .NUM_NEURONS(NN), .NUM_INPUTS(NI), .OUTPUT_WIDTH(OW), .MEM_LATENCY(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cyc; int pix; int wgt; } rd_t;
  typedef struct { int cyc; int cls; int score; int err; } done_t;

  rd_t   rd_q[$];
  int    clr_q[$];
  int    last_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int busy_cnt = 0;
  bit done_seen = 1'b0;

  // MAC stub: result picked by the neuron whose weights were read, L=2.
  logic signed [OW-1:0] scores [NN];
  logic inj = 1'b0;
  logic d1, d2;
  int cur_n;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_n <= 0;
      d1    <= 1'b0;
      d2    <= 1'b0;
    end else begin
      if (bus.mem_rd_en) cur_n <= int'(bus.wgt_addr) / NI;
      d1 <= bus.mac_last;
      d2 <= d1;
    end
  end
  assign bus.mac_valid  = d2 | inj;
  assign bus.mac_result = scores[cur_n];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected events whenever the DUT presents one.
  always @(negedge clk) begin
    int rel;
    rd_t er;
    done_t ed;
    rel = cyc - start_cyc;
    if (rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.mem_rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", rel, -1);
        else begin
          er = rd_q.pop_front();
          chk("rd_cycle", rel, er.cyc);
          chk("pix_addr", bus.pix_addr, er.pix);
          chk("wgt_addr", bus.wgt_addr, er.wgt);
        end
      end
      if (bus.mac_clr) begin
        if (clr_q.size() == 0) chk("clr_unexpected", rel, -1);
        else chk("mac_clr_cycle", rel, clr_q.pop_front());
      end
      if (bus.mac_last) begin
        if (last_q.size() == 0) chk("last_unexpected", rel, -1);
        else begin
          chk("mac_last_cycle", rel, last_q.pop_front());
          chk("mac_last_with_en", bus.mac_en, 1);
        end
      end
      if (bus.done) begin
        done_seen = 1'b1;
        if (done_q.size() == 0) chk("done_unexpected", rel, -1);
        else begin
          ed = done_q.pop_front();
          chk("done_cycle", rel, ed.cyc);
          chk("class_out", bus.class_out, ed.cls);
          chk("class_score", $signed(bus.class_score), ed.score);
          chk("err_at_done", bus.err, ed.err);
          chk("busy_at_done", bus.busy, 1);
          chk("busy_cycles", busy_cnt, ed.cyc);
        end
      end
    end
  end

  task automatic push_expect(input int cls, input int score, input int err);
    for (int n = 0; n < NN; n++) begin
      clr_q.push_back(1 + 8 * n);
      last_q.push_back(6 + 8 * n);
      for (int i = 0; i < NI; i++)
        rd_q.push_back('{cyc: 2 + 8 * n + i, pix: i, wgt: NI * n + i});
    end
    done_q.push_back('{cyc: 25, cls: cls, score: score, err: err});
  endtask

  task automatic set_scores(input int s0, input int s1, input int s2);
    scores[0] = OW'(s0);
    scores[1] = OW'(s1);
    scores[2] = OW'(s2);
  endtask

  task automatic run_layer(input int s0, input int s1, input int s2,
                           input int ecls, input int escore, input int eerr,
                           input bit second_start, input bit stray, input bit start_inj);
    int rel;
    set_scores(s0, s1, s2);
    push_expect(ecls, escore, eerr);
    done_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    inj       = start_inj;
    start_cyc = cyc;
    busy_cnt  = 0;
    @(negedge clk);
    bus.start = 1'b0;
    inj       = 1'b0;
    chk("err_after_start", bus.err, start_inj ? 1 : 0);
    chk("busy_rise", bus.busy, 1);
    for (int k = 0; k < 100 && !done_seen; k++) begin
      @(negedge clk);
      rel = cyc - start_cyc;
      if (second_start) bus.start = (rel == 10);
      if (stray) inj = (rel == 3);
    end
    bus.start = 1'b0;
    inj       = 1'b0;
    if (!done_seen) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
    chk("done_after_done", bus.done, 0);
    chk("rd_left", rd_q.size(), 0);
    chk("clr_left", clr_q.size(), 0);
    chk("last_left", last_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    set_scores(0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_class", bus.class_out, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_layer(5, 7, 7, 1, 7, 0, 1'b1, 1'b0, 1'b0);
    run_layer(-3, -1, -8, 1, -1, 0, 1'b0, 1'b0, 1'b0);
    run_layer(3, -2, 6, 2, 6, 1, 1'b0, 1'b1, 1'b0);
    run_layer(1, 2, 3, 2, 3, 0, 1'b0, 1'b0, 1'b0);

    // Abort mid-STREAM with an asynchronous reset.
    set_scores(9, 9, 9);
    push_expect(0, 9, 0);
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc;
    busy_cnt  = 0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    chk("busy_before_abort", bus.busy, 1);
    chk("class_before_abort", bus.class_out, 2);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_rd_en", bus.mem_rd_en, 0);
    chk("abort_pix", bus.pix_addr, 0);
    chk("abort_wgt", bus.wgt_addr, 0);
    chk("abort_clr", bus.mac_clr, 0);
    chk("abort_en", bus.mac_en, 0);
    chk("abort_last", bus.mac_last, 0);
    chk("abort_class", bus.class_out, 0);
    chk("abort_score", $signed(bus.class_score), 0);
    rd_q.delete();
    clr_q.delete();
    last_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_layer(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_layer(4, 4, 1, 0, 4, 1, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
